// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a registered carry produces a
// WIDTH-bit sum LSB-first over WIDTH cycles, then pulses done for one cycle.

// Single-bit full adder slice.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, acc_q, sum_q;
    logic [WIDTH-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, cout_q, busy_q, done_q;
    logic               s_bit, c_bit;
    logic               last;

    full_adder u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (s_bit),
        .co (c_bit)
    );

    assign last = (cnt_q == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB; the shift form keeps every acc bit in use.
    assign acc_nxt = WIDTH'({s_bit, acc_q} >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept start in IDLE, leave RUN after the last bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (last)  state_d = StIdle;
        endcase
    end

    // Datapath: operand capture, bit-serial shifting and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_d == StRun);
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (start) begin
                    a_sh_q  <= a;
                    b_sh_q  <= b;
                    carry_q <= cin;
                    cnt_q   <= '0;
                end
            end else begin
                carry_q <= c_bit;
                acc_q   <= acc_nxt;
                a_sh_q  <= a_sh_q >> 1;
                b_sh_q  <= b_sh_q >> 1;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last) begin
                    sum_q  <= acc_nxt;
                    cout_q <= c_bit;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16. Expected
// results come from plain integer addition of the applied operands.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, cin8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16;
    logic [15:0] sum16;

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] last_res8 = '0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic cur_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic [32:0] cur_res(input int w);
        if (w == 8) return {24'd0, cout8, sum8};
        return {16'd0, cout16, sum16};
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] ta,
                         input logic [31:0] tb, input logic tc);
        if (w == 8) begin
            start8 = st; a8 = ta[7:0]; b8 = tb[7:0]; cin8 = tc;
        end else begin
            start16 = st; a16 = ta[15:0]; b16 = tb[15:0]; cin16 = tc;
        end
    endtask

    // One complete operation: checks latency, busy length, result and done width.
    task automatic op(input int w, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tc, input string tag);
        logic [32:0] expv;
        int lat;
        int bcnt;
        expv = 33'(ta) + 33'(tb) + 33'(tc);
        @(negedge clk);
        drive(w, 1'b1, ta, tb, tc);
        @(negedge clk);
        // Scramble operands after acceptance; they must not affect the result.
        drive(w, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        lat = 0;
        bcnt = 0;
        while (!cur_done(w) && lat < 4 * w) begin
            if (cur_busy(w)) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(w));
        chk({tag, " busy cycles"}, 64'(bcnt), 64'(w));
        chk({tag, " busy during done"}, 64'(cur_busy(w)), 64'd0);
        chk({tag, " result"}, 64'(cur_res(w)), 64'(expv));
        @(negedge clk);
        chk({tag, " done width"}, 64'(cur_done(w)), 64'd0);
        chk({tag, " result hold"}, 64'(cur_res(w)), 64'(expv));
        if (w == 8) last_res8 = expv;
    endtask

    initial begin
        logic [32:0] h1, h2, prev;
        logic [31:0] ta, tb;
        logic        tc;
        int          dcount;
        logic        dexp;

        // Power-on reset.
        #12;
        chk("reset busy8", 64'(busy8), 64'd0);
        chk("reset done8", 64'(done8), 64'd0);
        chk("reset res8", 64'(cur_res(8)), 64'd0);
        chk("reset res16", 64'(cur_res(16)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post-reset busy8", 64'(busy8), 64'd0);
        chk("post-reset res8", 64'(cur_res(8)), 64'd0);

        // Basic add and carry corners.
        op(8, 32'h3C, 32'h5A, 1'b0, "basic");
        op(8, 32'hFF, 32'h01, 1'b0, "ff+01");
        op(8, 32'hFF, 32'hFF, 1'b1, "ff+ff+1");
        op(8, 32'h00, 32'h00, 1'b1, "0+0+1");

        // Asynchronous reset mid-cycle with no edge: outputs clear at once.
        op(8, 32'hA5, 32'h7E, 1'b1, "pre-reset");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(busy8), 64'd0);
        chk("async reset done", 64'(done8), 64'd0);
        chk("async reset res", 64'(cur_res(8)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("released res", 64'(cur_res(8)), 64'd0);
        chk("released busy", 64'(busy8), 64'd0);
        last_res8 = '0;

        // Handshake: start held high, operands changing every cycle.
        op(8, 32'h40, 32'h02, 1'b0, "hs prelude");
        prev = last_res8;
        h1 = 33'h11 + 33'h22;
        h2 = '0;
        @(negedge clk);
        drive(8, 1'b1, 32'h11, 32'h22, 1'b0);
        for (int t = 1; t <= 18; t++) begin
            @(negedge clk);
            dexp = (t == 9) || (t == 18);
            chk("hs done", 64'(done8), 64'(dexp));
            chk("hs busy", 64'(busy8), 64'(!dexp));
            if (t < 9)       chk("hs hold prev", 64'(cur_res(8)), 64'(prev));
            else if (t < 18) chk("hs result1", 64'(cur_res(8)), 64'(h1));
            else             chk("hs result2", 64'(cur_res(8)), 64'(h2));
            if (t == 9) begin
                ta = 32'($urandom_range(0, 255));
                tb = 32'($urandom_range(0, 255));
                tc = 1'($urandom_range(0, 1));
                h2 = 33'(ta) + 33'(tb) + 33'(tc);
                drive(8, 1'b1, ta, tb, tc);
            end else if (t == 18) begin
                drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
            end else begin
                drive(8, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
        end
        @(negedge clk);
        chk("hs idle after", 64'(busy8 | done8), 64'd0);

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(8, 1'b1, 32'h12, 32'h34, 1'b0);
        @(negedge clk);
        drive(8, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop reset res", 64'(cur_res(8)), 64'd0);
        chk("midop reset busy", 64'(busy8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        chk("midop no done", 64'(dcount), 64'd0);
        chk("midop res zero", 64'(cur_res(8)), 64'd0);
        op(8, 32'h12, 32'h34, 1'b0, "after abort");

        // Random regression at both widths.
        for (int i = 0; i < 1000; i++) begin
            op(8, 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), "rand8");
        end
        for (int i = 0; i < 1000; i++) begin
            op(16, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), "rand16");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
